// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding word read at a
// time, buffers returned words in a 2-entry queue and hands them to decode.
// Fetch pauses after a BEQ/BNEQ until the branch is resolved or redirected.
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] PC_STEP  = 64'd1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata,
   output logic        ir_valid,
   output logic [63:0] IR,
   output logic [63:0] ir_pc,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        br_resolved
);

   localparam int DEPTH = 2;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t      state_reg, state_next;
   logic [63:0] pc_reg, pc_next;
   logic [63:0] discard_addr_reg, discard_addr_next;
   logic [1:0]  count_reg, count_next;
   logic        br_hold_reg, br_hold_next;
   logic        rd_ptr_reg, rd_ptr_next;
   logic        wr_ptr_reg, wr_ptr_next;
   logic        enq, deq, is_branch;

   logic [63:0] slot_ir [DEPTH];
   logic [63:0] slot_pc [DEPTH];

   // Queue storage: each slot captures {word, pc} when it is the tail and a
   // word arrives. Cleared on reset so IR/ir_pc read as zero afterwards.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [63:0] ir_entry_reg;
         logic [63:0] pc_entry_reg;

         // load this slot on an enqueue aimed at it
         always_ff @(posedge clk) begin
            if (rst) begin
               ir_entry_reg <= '0;
               pc_entry_reg <= '0;
            end else if (enq && (wr_ptr_reg == 1'(gi))) begin
               ir_entry_reg <= mem_rdata;
               pc_entry_reg <= pc_reg;
            end
         end

         assign slot_ir[gi] = ir_entry_reg;
         assign slot_pc[gi] = pc_entry_reg;
      end
   endgenerate

   assign ir_valid = (count_reg != 2'd0);
   assign IR       = slot_ir[rd_ptr_reg];
   assign ir_pc    = slot_pc[rd_ptr_reg];
   assign mem_req  = (state_reg == REQ) || (state_reg == DISCARD);
   // In DISCARD the read in flight belongs to the pre-redirect address.
   assign mem_addr = (state_reg == DISCARD) ? discard_addr_reg : pc_reg;

   // Next-state, queue bookkeeping and PC update; redirect overrides all.
   always_comb begin
      enq               = (state_reg == REQ) && mem_ack && !redirect;
      deq               = ir_valid && ir_ready && !redirect;
      is_branch         = (mem_rdata[63:58] == 6'h04) || (mem_rdata[63:58] == 6'h05);
      state_next        = state_reg;
      pc_next           = pc_reg;
      discard_addr_next = discard_addr_reg;
      br_hold_next      = br_hold_reg;
      rd_ptr_next       = rd_ptr_reg;
      wr_ptr_next       = wr_ptr_reg;
      count_next        = count_reg + 2'(enq) - 2'(deq);

      if (enq) begin
         wr_ptr_next = ~wr_ptr_reg;
         pc_next     = pc_reg + PC_STEP;
      end
      if (deq) begin
         rd_ptr_next = ~rd_ptr_reg;
      end
      if (br_resolved) begin
         br_hold_next = 1'b0;
      end

      if (redirect) begin
         count_next   = 2'd0;
         rd_ptr_next  = 1'b0;
         wr_ptr_next  = 1'b0;
         br_hold_next = 1'b0;
         pc_next      = redirect_pc;
         if ((state_reg == REQ || state_reg == DISCARD) && !mem_ack) begin
            // read still in flight: let it finish, then throw it away
            state_next = DISCARD;
            if (state_reg == REQ) begin
               discard_addr_next = pc_reg;
            end
         end else begin
            state_next = REQ;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (count_next != 2'd2 && !br_hold_reg) begin
                  state_next = REQ;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (is_branch) begin
                     br_hold_next = 1'b1;
                     state_next   = IDLE;
                  end else if (count_next == 2'd2) begin
                     state_next = IDLE;
                  end
               end
            end
            DISCARD: begin
               if (mem_ack) begin
                  state_next = REQ;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         pc_reg           <= RESET_PC;
         discard_addr_reg <= RESET_PC;
         count_reg        <= 2'd0;
         br_hold_reg      <= 1'b0;
         rd_ptr_reg       <= 1'b0;
         wr_ptr_reg       <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         discard_addr_reg <= discard_addr_next;
         count_reg        <= count_next;
         br_hold_reg      <= br_hold_next;
         rd_ptr_reg       <= rd_ptr_next;
         wr_ptr_reg       <= wr_ptr_next;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a behavioural instruction memory with
// per-address wait states, a scoreboard of expected {IR, pc} deliveries and a
// log of acknowledged read addresses checked against directed expectations.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        ir_valid;
   logic [63:0] IR;
   logic [63:0] ir_pc;
   logic        ir_ready;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        br_resolved;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rcyc;

   logic [127:0] exp_q[$];      // expected {IR, ir_pc} in delivery order
   logic [63:0]  ack_log[$];    // addresses acknowledged by memory
   int           ack_cyc[$];    // cycle number of each ack
   logic [63:0]  exp_acks[$];

   instr_fetch_unit dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir_valid(ir_valid), .IR(IR), .ir_pc(ir_pc), .ir_ready(ir_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .br_resolved(br_resolved)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Program image: opcode field chosen per address, low bits tag the address.
   function automatic logic [63:0] word(input logic [63:0] a);
      logic [5:0] op;
      case (a)
         64'h3, 64'h22, 64'h42: op = 6'h04;
         64'h6, 64'h102:        op = 6'h05;
         64'h1:                 op = 6'h06;
         64'h41:                op = 6'h03;
         default:               op = 6'h00;
      endcase
      return {op, a[57:0] ^ 58'h0A5A5};
   endfunction

   function automatic int wait_states(input logic [63:0] a);
      case (a)
         64'h5:   return 3;
         64'h101: return 2;
         64'h31:  return 5;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s value=%h", name, act);
      end
   endtask

   task automatic push_exp(input logic [63:0] pc);
      exp_q.push_back({word(pc), pc});
   endtask

   task automatic check_acks(input string name);
      check({name, "_len"}, 64'(ack_log.size()), 64'(exp_acks.size()));
      for (int i = 0; i < ack_log.size() && i < exp_acks.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), ack_log[i], exp_acks[i]);
      end
      ack_log.delete();
      ack_cyc.delete();
      exp_acks.delete();
   endtask

   // Memory: a new request is seen when mem_req is high and none is in flight.
   initial begin
      bit busy;
      int wait_left;
      busy = 0;
      wait_left = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!mem_req) begin
            busy = 0;
            mem_ack = 1'b0;
         end else begin
            if (!busy) begin
               busy = 1;
               wait_left = wait_states(mem_addr);
            end
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               mem_rdata = word(mem_addr);
               busy = 0;
            end else begin
               mem_ack = 1'b0;
               wait_left--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted IR, logs acks and checks
   // that the request address is held while a read is outstanding.
   initial begin
      logic [127:0] e;
      logic         prev_req;
      logic         prev_ack;
      logic [63:0]  prev_addr;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst && ir_valid && ir_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ir_unexpected actual pc=%h ir=%h required none", ir_pc, IR);
            end else begin
               e = exp_q.pop_front();
               if ({IR, ir_pc} !== e) begin
                  errors++;
                  $display("FAIL ir_pop actual pc=%h ir=%h required pc=%h ir=%h",
                           ir_pc, IR, e[63:0], e[127:64]);
               end else begin
                  $display("ok   ir_pop pc=%h ir=%h", ir_pc, IR);
               end
            end
         end
         if (mem_req && mem_ack) begin
            ack_log.push_back(mem_addr);
            ack_cyc.push_back(cyc);
         end
         if (!rst && mem_req && prev_req && !prev_ack) begin
            checks++;
            if (mem_addr !== prev_addr) begin
               errors++;
               $display("FAIL addr_stable actual=%h required=%h", mem_addr, prev_addr);
            end
         end
         prev_req  = mem_req && !rst;
         prev_ack  = mem_ack;
         prev_addr = mem_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; br_resolved = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req",  64'(mem_req),  64'd0);
      check("rst_mem_addr", mem_addr,      64'h0);
      check("rst_ir_valid", 64'(ir_valid), 64'd0);
      check("rst_IR",       IR,            64'h0);
      check("rst_ir_pc",    ir_pc,         64'h0);

      // release reset with decode stalled: two words fill the queue, then stop
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); check("first_req_not_yet", 64'(mem_req), 64'd0);
      @(negedge clk); check("first_req", 64'(mem_req), 64'd1);
      check("first_req_addr", mem_addr, 64'h0);
      repeat (8) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h0, 64'h1};
      check_acks("full_acks");
      check("full_no_req",   64'(mem_req),  64'd0);
      check("full_valid",    64'(ir_valid), 64'd1);
      check("full_head_pc",  ir_pc,         64'h0);

      // drain: PCs 0,1 in order, fetch resumes at 2, stops after BEQ at 3
      push_exp(64'h0); push_exp(64'h1); push_exp(64'h2); push_exp(64'h3);
      @(posedge clk); #1; ir_ready = 1'b1;
      @(negedge clk); check("resume_not_yet", 64'(mem_req), 64'd0);
      @(negedge clk); check("resume_req", 64'(mem_req), 64'd1);
      check("resume_addr", mem_addr, 64'h2);
      repeat (8) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h2, 64'h3};
      check_acks("beq_acks");
      check("beq_hold_no_req", 64'(mem_req), 64'd0);
      check("beq_drained", 64'(exp_q.size()), 64'd0);

      // branch resolved not-taken: sequential fetch 4,5,6 then BNEQ at 6 holds
      push_exp(64'h4); push_exp(64'h5); push_exp(64'h6);
      @(posedge clk); #1; br_resolved = 1'b1;
      @(posedge clk); #1; br_resolved = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h4, 64'h5, 64'h6};
      check_acks("resolved_acks");
      check("bneq_hold_no_req", 64'(mem_req), 64'd0);
      check("resolved_drained", 64'(exp_q.size()), 64'd0);

      // taken branch from IDLE: redirect to 0x40, back-to-back fetches
      push_exp(64'h40); push_exp(64'h41); push_exp(64'h42);
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 64'h40; rcyc = cyc;
      @(posedge clk); #1; redirect = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < ack_cyc.size() && i < 3; i++) begin
         check($sformatf("redir_ack_cycle%0d", i), 64'(ack_cyc[i] - rcyc), 64'(i + 1));
      end
      exp_acks = '{64'h40, 64'h41, 64'h42};
      check_acks("redir_acks");
      check("redir_drained", 64'(exp_q.size()), 64'd0);

      // redirect while the read at 5 is waiting: it completes and is dropped
      push_exp(64'h100); push_exp(64'h101); push_exp(64'h102);
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 64'h5;
      @(posedge clk); #1; redirect_pc = 64'h100;
      @(negedge clk);
      check("disc_wait_req",  64'(mem_req), 64'd1);
      check("disc_wait_addr", mem_addr,     64'h5);
      @(posedge clk); #1; redirect = 1'b0;
      @(negedge clk);
      check("disc_flushed",   64'(ir_valid), 64'd0);
      check("disc_held_addr", mem_addr,      64'h5);
      repeat (15) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h5, 64'h100, 64'h101, 64'h102};
      check_acks("disc_acks");
      check("disc_drained", 64'(exp_q.size()), 64'd0);

      // redirect coinciding with an ack and a dequeue
      push_exp(64'h20); push_exp(64'h21); push_exp(64'h22);
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 64'h10;
      @(posedge clk); #1; redirect = 1'b0;
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 64'h20;
      @(negedge clk);
      check("sc_ack_present",  64'(mem_ack),  64'd1);
      check("sc_head_present", 64'(ir_valid), 64'd1);
      check("sc_ack_addr",     mem_addr,      64'h11);
      @(posedge clk); #1; redirect = 1'b0;
      @(negedge clk);
      check("sc_flushed",  64'(ir_valid), 64'd0);
      check("sc_new_req",  64'(mem_req),  64'd1);
      check("sc_new_addr", mem_addr,      64'h20);
      repeat (10) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h10, 64'h11, 64'h20, 64'h21, 64'h22};
      check_acks("sc_acks");
      check("sc_drained", 64'(exp_q.size()), 64'd0);

      // reset with a buffered word and a read outstanding
      ir_ready = 1'b0;
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 64'h30;
      @(posedge clk); #1; redirect = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_valid", 64'(ir_valid), 64'd1);
      check("pre_rst_req",   64'(mem_req),  64'd1);
      check("pre_rst_addr",  mem_addr,      64'h31);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst2_mem_req",  64'(mem_req),  64'd0);
      check("rst2_mem_addr", mem_addr,      64'h0);
      check("rst2_ir_valid", 64'(ir_valid), 64'd0);
      check("rst2_IR",       IR,            64'h0);
      check("rst2_ir_pc",    ir_pc,         64'h0);
      exp_acks = '{64'h30};
      check_acks("rst2_pre_acks");
      push_exp(64'h0); push_exp(64'h1); push_exp(64'h2); push_exp(64'h3);
      @(posedge clk); #1; rst = 1'b0; ir_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      exp_acks = '{64'h0, 64'h1, 64'h2, 64'h3};
      check_acks("rst2_acks");
      check("rst2_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
